// File: rtl/vend_payout_ctrl_if.sv
// Handshake bundle between the payout controller and the vending machine hardware.
//   master : controller side (drives motor/hopper requests and status)
//   slave  : machine side (drives job request, acknowledges and stock flags)
// Signals:
//   start, vend_en, change_in[3:0]      job request, item flag, change owed (nickels)
//   motor_req / motor_ack               item motor request / dispensed acknowledge
//   hopper_dime, hopper_nickel          one-cycle coin eject pulses
//   hopper_ack                          ejected coin confirmed
//   dime_empty, nickel_empty            hopper stock empty flags
//   fault_clr                           clears a latched fault
//   busy, done, fault                   status
//   rem_out[3:0], state_cur[2:0]        remaining change and current state
interface vend_payout_ctrl_if;
    logic       start;
    logic       vend_en;
    logic [3:0] change_in;
    logic       motor_req;
    logic       motor_ack;
    logic       hopper_dime;
    logic       hopper_nickel;
    logic       hopper_ack;
    logic       dime_empty;
    logic       nickel_empty;
    logic       fault_clr;
    logic       busy;
    logic       done;
    logic       fault;
    logic [3:0] rem_out;
    logic [2:0] state_cur;

    modport master (
        input  start, vend_en, change_in, motor_ack, hopper_ack,
               dime_empty, nickel_empty, fault_clr,
        output motor_req, hopper_dime, hopper_nickel, busy, done, fault,
               rem_out, state_cur
    );

    modport slave (
        output start, vend_en, change_in, motor_ack, hopper_ack,
               dime_empty, nickel_empty, fault_clr,
        input  motor_req, hopper_dime, hopper_nickel, busy, done, fault,
               rem_out, state_cur
    );
endinterface

// File: rtl/vend_payout_ctrl.sv
// Vending payout controller: optionally dispenses an item, then pays change owed
// using dimes where possible (nickels otherwise), one coin per PAY/WAIT round.
// Any acknowledge not seen within TIMEOUT cycles latches a fault until fault_clr.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  vend_payout_ctrl_if.master handshake/status bundle
// All outputs are decoded from registers only; the coin eject pulses are
// registered, so a pulse is visible in the first WAIT cycle after the PAY
// decision.
module vend_payout_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    vend_payout_ctrl_if.master        bus
);

    typedef enum logic [2:0] {
        StIdle  = 3'b000,
        StVend  = 3'b001,
        StPay   = 3'b010,
        StWait  = 3'b011,
        StDone  = 3'b100,
        StFault = 3'b101
    } state_e;

    // Last counter value before the timeout fires; ack in this cycle still wins.
    localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [3:0] rem_q, rem_d;
    logic       coin_q, coin_d;     // 1 = dime in flight, 0 = nickel
    logic [7:0] tmo_q, tmo_d;
    logic       dime_q, dime_d;
    logic       nickel_q, nickel_d;
    logic [3:0] rem_new;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            rem_q    <= 4'd0;
            coin_q   <= 1'b0;
            tmo_q    <= 8'd0;
            dime_q   <= 1'b0;
            nickel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            coin_q   <= coin_d;
            tmo_q    <= tmo_d;
            dime_q   <= dime_d;
            nickel_q <= nickel_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        coin_d   = coin_q;
        tmo_d    = tmo_q;
        dime_d   = 1'b0;
        nickel_d = 1'b0;
        rem_new  = coin_q ? (rem_q - 4'd2) : (rem_q - 4'd1);

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    rem_d = bus.change_in;
                    if (bus.vend_en) begin
                        state_d = StVend;
                        tmo_d   = 8'd0;
                    end else if (bus.change_in != 4'd0) begin
                        state_d = StPay;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StVend: begin
                if (bus.motor_ack) begin
                    state_d = (rem_q != 4'd0) ? StPay : StDone;
                end else if (tmo_q == TmoLast) begin
                    state_d = StFault;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            StPay: begin
                if (rem_q == 4'd0) begin
                    state_d = StDone;
                end else if (rem_q >= 4'd2 && !bus.dime_empty) begin
                    dime_d  = 1'b1;
                    coin_d  = 1'b1;
                    tmo_d   = 8'd0;
                    state_d = StWait;
                end else if (!bus.nickel_empty) begin
                    nickel_d = 1'b1;
                    coin_d   = 1'b0;
                    tmo_d    = 8'd0;
                    state_d  = StWait;
                end else begin
                    state_d = StFault;
                end
            end
            StWait: begin
                if (bus.hopper_ack) begin
                    rem_d   = rem_new;
                    state_d = (rem_new != 4'd0) ? StPay : StDone;
                end else if (tmo_q == TmoLast) begin
                    state_d = StFault;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            StDone: begin
                rem_d   = 4'd0;
                state_d = StIdle;
            end
            StFault: begin
                // rem is held for diagnosis until the fault is cleared
                if (bus.fault_clr) begin
                    rem_d   = 4'd0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.motor_req     = (state_q == StVend);
    assign bus.hopper_dime   = dime_q;
    assign bus.hopper_nickel = nickel_q;
    assign bus.busy          = (state_q != StIdle);
    assign bus.done          = (state_q == StDone);
    assign bus.fault         = (state_q == StFault);
    assign bus.rem_out       = rem_q;
    assign bus.state_cur     = state_q;

endmodule

// File: tb/tb_vend_payout_ctrl.sv
// Directed bench for vend_payout_ctrl with hand-computed expectations.
// Output vector order: {motor_req, hopper_dime, hopper_nickel, busy, done, fault}
module tb_vend_payout_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    vend_payout_ctrl_if bus ();

    vend_payout_ctrl #(
        .TIMEOUT(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {bus.motor_req, bus.hopper_dime, bus.hopper_nickel, bus.busy, bus.done, bus.fault};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input string tag, input logic [2:0] st, input logic [5:0] o,
                             input logic [3:0] rem);
        check({tag, ".state"}, 32'(bus.state_cur), 32'(st));
        check({tag, ".outs"}, 32'(outs()), 32'(o));
        check({tag, ".rem"}, 32'(bus.rem_out), 32'(rem));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.start        = 1'b0;
        bus.vend_en      = 1'b0;
        bus.change_in    = 4'd0;
        bus.motor_ack    = 1'b0;
        bus.hopper_ack   = 1'b0;
        bus.dime_empty   = 1'b0;
        bus.nickel_empty = 1'b0;
        bus.fault_clr    = 1'b0;
        tick();
        tick();
        expect_st("reset", 3'b000, 6'b000000, 4'd0);
        rst = 1'b0;
        tick();
        expect_st("post_reset", 3'b000, 6'b000000, 4'd0);

        // Item plus 3 nickels of change: dime then nickel.
        bus.start = 1'b1; bus.vend_en = 1'b1; bus.change_in = 4'd3;
        tick();
        bus.start = 1'b0; bus.vend_en = 1'b0; bus.change_in = 4'd0;
        expect_st("t1.vend0", 3'b001, 6'b100100, 4'd3);
        tick();
        expect_st("t1.vend1", 3'b001, 6'b100100, 4'd3);
        tick();
        expect_st("t1.vend2", 3'b001, 6'b100100, 4'd3);
        bus.motor_ack = 1'b1;
        tick();
        bus.motor_ack = 1'b0;
        expect_st("t1.pay0", 3'b010, 6'b000100, 4'd3);
        tick();
        expect_st("t1.wait_dime", 3'b011, 6'b010100, 4'd3);
        bus.hopper_ack = 1'b1;
        tick();
        bus.hopper_ack = 1'b0;
        expect_st("t1.pay1", 3'b010, 6'b000100, 4'd1);
        tick();
        expect_st("t1.wait_nick", 3'b011, 6'b001100, 4'd1);
        bus.hopper_ack = 1'b1;
        tick();
        bus.hopper_ack = 1'b0;
        expect_st("t1.done", 3'b100, 6'b000110, 4'd0);
        tick();
        expect_st("t1.idle", 3'b000, 6'b000000, 4'd0);

        // No dimes: 4 nickels, rem 4,3,2,1,0.
        bus.dime_empty = 1'b1;
        bus.start = 1'b1; bus.change_in = 4'd4;
        tick();
        bus.start = 1'b0; bus.change_in = 4'd0;
        for (int i = 4; i > 0; i--) begin
            expect_st($sformatf("t2.pay%0d", i), 3'b010, 6'b000100, 4'(i));
            tick();
            expect_st($sformatf("t2.wait%0d", i), 3'b011, 6'b001100, 4'(i));
            bus.hopper_ack = 1'b1;
            tick();
            bus.hopper_ack = 1'b0;
        end
        expect_st("t2.done", 3'b100, 6'b000110, 4'd0);
        tick();
        expect_st("t2.idle", 3'b000, 6'b000000, 4'd0);
        bus.dime_empty = 1'b0;

        // Motor never acknowledges: fault after 15 VEND cycles.
        bus.start = 1'b1; bus.vend_en = 1'b1; bus.change_in = 4'd2;
        tick();
        bus.start = 1'b0; bus.vend_en = 1'b0; bus.change_in = 4'd0;
        for (int i = 0; i < 14; i++) tick();
        expect_st("t3.vend14", 3'b001, 6'b100100, 4'd2);
        tick();
        expect_st("t3.fault", 3'b101, 6'b000101, 4'd2);
        bus.start = 1'b1; bus.change_in = 4'd7;
        tick();
        bus.start = 1'b0; bus.change_in = 4'd0;
        expect_st("t3.fault_hold", 3'b101, 6'b000101, 4'd2);
        bus.fault_clr = 1'b1;
        tick();
        bus.fault_clr = 1'b0;
        expect_st("t3.cleared", 3'b000, 6'b000000, 4'd0);

        // Ack on the last allowed cycle wins over the timeout.
        bus.start = 1'b1; bus.vend_en = 1'b1;
        tick();
        bus.start = 1'b0; bus.vend_en = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        bus.motor_ack = 1'b1;
        tick();
        bus.motor_ack = 1'b0;
        expect_st("t4.ack_wins", 3'b100, 6'b000110, 4'd0);
        tick();

        // Nothing to do: straight to DONE.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        expect_st("t5.done", 3'b100, 6'b000110, 4'd0);
        tick();
        expect_st("t5.idle", 3'b000, 6'b000000, 4'd0);

        // One nickel owed but nickel hopper empty.
        bus.nickel_empty = 1'b1;
        bus.start = 1'b1; bus.change_in = 4'd1;
        tick();
        bus.start = 1'b0; bus.change_in = 4'd0;
        expect_st("t6.pay", 3'b010, 6'b000100, 4'd1);
        tick();
        expect_st("t6.fault", 3'b101, 6'b000101, 4'd1);
        bus.nickel_empty = 1'b0;
        bus.fault_clr = 1'b1;
        tick();
        bus.fault_clr = 1'b0;

        // Reset while waiting for a coin; extra start while busy is ignored.
        bus.start = 1'b1; bus.change_in = 4'd3;
        tick();
        bus.start = 1'b0; bus.change_in = 4'd0;
        tick();
        expect_st("t7.wait", 3'b011, 6'b010100, 4'd3);
        bus.start = 1'b1; bus.vend_en = 1'b1; bus.change_in = 4'd9;
        tick();
        bus.start = 1'b0; bus.vend_en = 1'b0; bus.change_in = 4'd0;
        expect_st("t7.start_ignored", 3'b011, 6'b000100, 4'd3);
        #2;
        rst = 1'b1;
        #1;
        expect_st("t7.async_rst", 3'b000, 6'b000000, 4'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        expect_st("t7.after_rst", 3'b000, 6'b000000, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vend_payout_ctrl.md
VEND_PAYOUT_CTRL -- requirements
Module: vend_payout_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 15, max cycles waited for any acknowledge before faulting (range 1..255).
REQ-002 clk  input  1  system clock, rising-edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  job request; sampled only in IDLE.
REQ-005 vend_en  input  1  job includes item dispense.
REQ-006 change_in  input  4  change owed, nickel units (0..15).
REQ-007 motor_req  output  1  item motor request, held until motor_ack.
REQ-008 motor_ack  input  1  item dispensed.
REQ-009 hopper_dime / hopper_nickel  output  1 each  one-cycle coin eject pulse.
REQ-010 hopper_ack  input  1  ejected coin confirmed.
REQ-011 dime_empty / nickel_empty  input  1 each  hopper stock empty.
REQ-012 fault_clr  input  1  clears FAULT.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle job-complete pulse.
REQ-015 fault  output  1  high while in FAULT.
REQ-016 rem_out  output  4  remaining change, nickel units.
REQ-017 state_cur  output  3  current state encoding.

Function
REQ-018 States: IDLE 000, VEND 001, PAY 010, WAIT 011, DONE 100, FAULT 101; 110/111 return to IDLE next cycle.
REQ-019 All outputs Moore, decoded from state and registers only; no input-to-output combinational path.
REQ-020 IDLE, start=1: rem <= change_in; next = VEND if vend_en, else PAY if change_in!=0, else DONE.
REQ-021 start outside IDLE ignored; change_in/vend_en sampled only on the accepting edge.
REQ-022 VEND: motor_req=1; motor_ack=1 -> PAY if rem!=0, else DONE.
REQ-023 PAY lasts exactly one cycle: rem>=2 and !dime_empty -> hopper_dime=1, coin=dime; else if !nickel_empty -> hopper_nickel=1, coin=nickel; else -> FAULT with no pulse.
REQ-024 Dime unavailable: change paid entirely in nickels (dime_empty substitution).
REQ-025 PAY -> WAIT when a pulse is issued; coin type latched for WAIT.
REQ-026 WAIT: hopper_ack=1 -> rem <= rem-2 (dime) or rem-1 (nickel); next = PAY if new rem!=0, else DONE.
REQ-027 rem never underflows; dime only chosen when rem>=2.
REQ-028 Timeout counter cleared on entry to VEND and WAIT, increments each cycle there; reaching TIMEOUT without ack -> FAULT.
REQ-029 Ack in same cycle counter reaches TIMEOUT: ack wins, no fault.
REQ-030 motor_ack outside VEND and hopper_ack outside WAIT ignored.
REQ-031 DONE: done=1 for one cycle, rem=0, -> IDLE.
REQ-032 FAULT: fault=1, busy=1, rem held for diagnosis; fault_clr=1 -> IDLE with rem cleared; start ignored.

Reset
REQ-033 rst=1 asynchronously forces IDLE, rem=0, coin=nickel, timeout counter=0.
REQ-034 During and after reset: motor_req, hopper_dime, hopper_nickel, busy, done, fault = 0; rem_out=0; state_cur=000.
REQ-035 Reset mid-job (any state) abandons job; no pulse or done issued afterward.

Verification
REQ-036 start, vend_en=1, change_in=3, stock full; motor_ack 3 cycles later -> motor_req 3 cycles, then hopper_dime pulse, ack -> rem 1, hopper_nickel pulse, ack -> rem 0, done pulse, IDLE.
REQ-037 start, vend_en=0, change_in=4, dime_empty=1 -> four hopper_nickel pulses, each after prior ack; rem 4,3,2,1,0; done.
REQ-038 start, vend_en=1, motor_ack held 0 -> FAULT (101) after TIMEOUT=15 cycles in VEND; fault=1 until fault_clr, then IDLE.
REQ-039 start, vend_en=0, change_in=0 -> state 100 next cycle, done=1 one cycle, no motor/hopper activity.
REQ-040 change_in=1, nickel_empty=1 -> PAY then FAULT, no hopper pulse, rem_out=1.
REQ-041 rst asserted in WAIT, and start pulsed while busy -> immediate IDLE, all outputs 0; extra start has no effect on rem or state.
